regfile_wb: RTL and testbench
=============================

# regfile_wb

Architectural register file that terminates the writeback path: it accepts the {RegWrite, WriteReg, WriteData} triple from the WB stage and serves the two decode-stage operand reads. It includes a same-cycle write-to-read bypass, hardwired register $0, and a per-register pending-write scoreboard. The scoreboard lets ID detect load-use hazards against loads still in flight. It sits between WB (write side) and ID (read, issue and stall side).

## Interface
- DATA_W, 32, register width
- ADDR_W, 5, register index width; register count is 2**ADDR_W
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- RegWrite  in  1  write enable from WB stage
- WriteReg  in  ADDR_W  destination index from WB stage
- WriteData  in  DATA_W  writeback data from WB stage
- ReadReg1, ReadReg2  in  ADDR_W  ID operand indices
- ReadData1, ReadData2  out  DATA_W  operand data (combinational, bypassed)
- IssueValid  in  1  ID issues a load writing IssueReg (marks pending)
- IssueReg  in  ADDR_W  destination of issued load
- KillValid  in  1  a pending load to KillReg was squashed and will never write back
- KillReg  in  ADDR_W  index to un-mark
- Pending1, Pending2  out  1  operand 1/2 awaits an in-flight load
- Stall  out  1  Pending1 | Pending2
- DbgReg  in  ADDR_W  debug read index
- DbgData  out  DATA_W  raw stored value, no bypass

## Operation
- Storage: 2**ADDR_W x DATA_W registers plus 2**ADDR_W pending bits. Index 0 is never written and never pending.
- Write: at posedge, if RegWrite && WriteReg != 0, then regs[WriteReg] <= WriteData.
- Read n: 0 if ReadRegn == 0; otherwise WriteData if RegWrite && WriteReg == ReadRegn; otherwise regs[ReadRegn].
- Pending n: pend[ReadRegn] && !(RegWrite && WriteReg == ReadRegn). A writeback in the same cycle resolves the hazard combinationally, consistent with the bypass.
- Scoreboard next state per index r != 0, in priority order:
  - Set if IssueValid && IssueReg == r.
  - Else clear if KillValid && KillReg == r.
  - Else clear if RegWrite && WriteReg == r.
  - Else hold.
- Issue beats a simultaneous writeback or kill to the same index, because the issue is the younger instruction.
- Issue to an already-pending index leaves the bit set. ID never issues a second load to a pending register: Stall blocks it.
- Writeback to a non-pending register (ALU result) is legal; the bit stays 0.
- IssueReg == 0 and KillReg == 0 are ignored.
- DbgData = regs[DbgReg]; 0 for index 0.

## Timing
- Reset (synchronous): all registers 0, all pending bits 0. In the cycle after reset, ReadData1/2 and DbgData read 0 unless bypassed; Pending1/2 and Stall read 0.
- Reset asserted in the same cycle as RegWrite or IssueValid: reset wins; no write or pending mark survives.
- Read latency: 0 cycles (combinational from index and current state).
- Write visibility:
  - Through the bypass in the same cycle.
  - Through storage and DbgData from the cycle after the posedge.
- Scoreboard:
  - A mark from IssueValid is visible on Pending from the next cycle.
  - A clear from writeback is visible combinationally in the same cycle, and in stored state from the next cycle.
- No handshakes; all inputs are sampled every cycle.

## Structure
- Shared package (mips_pkg):
  - DATA_W and ADDR_W defaults.
  - REG_ZERO constant (5'd0).
  - wb_bus_t struct {RegWrite, WriteReg, WriteData}, reused by WB stage outputs.
- One sub-module, reg_scoreboard: pending-bit array, set/clear priority, Pending1/2 generation.
- regfile_wb instantiates reg_scoreboard and owns the storage array and bypass muxes.

## Test plan
- Reset, then read all 32 indices on both ports -> ReadData = 0, Stall = 0; DbgData = 0 for all.
- RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF with ReadReg1=5 in the same cycle -> ReadData1 = 0xDEADBEEF that cycle; next cycle DbgReg=5 -> 0xDEADBEEF.
- RegWrite=1, WriteReg=0, WriteData=0x1234 with ReadReg2=0 -> ReadData2 = 0 that cycle and after; DbgData for index 0 = 0.
- IssueValid, IssueReg=8; next cycle ReadReg1=8 -> Pending1=1, Stall=1. Two cycles later RegWrite to 8 with 0x55 -> Pending1=0 and ReadData1=0x55 that cycle.
- Same cycle IssueValid reg 9 and RegWrite reg 9 -> next cycle Pending for reg 9 = 1. Later KillValid reg 9 -> next cycle Pending = 0 and storage unchanged.
- Write 0xA5A5A5A5 to reg 3, mark reg 3 pending, assert reset -> next cycle reg 3 reads 0 and Pending = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: default widths, the hardwired zero
// register index and the writeback bus bundle driven by the WB stage.
package mips_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic                  RegWrite;
    logic [DEF_ADDR_W-1:0] WriteReg;
    logic [DEF_DATA_W-1:0] WriteData;
  } wb_bus_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register marking a load
// still in flight. Issue sets, kill or writeback clears, issue wins because it
// belongs to the younger instruction. Pending outputs are masked by a same-cycle
// writeback so the hazard resolves together with the operand bypass.
module reg_scoreboard
  import mips_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              KillValid,
  input  logic [ADDR_W-1:0] KillReg,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              Pending1,
  output logic              Pending2
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Next-state per index: issue set, else kill clear, else writeback clear, else hold.
  always_comb begin
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (IssueValid && (IssueReg == ADDR_W'(r))) begin
        pend_d[r] = 1'b1;
      end else if (KillValid && (KillReg == ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end else if (RegWrite && (WriteReg == ADDR_W'(r))) begin
        pend_d[r] = 1'b0;
      end
    end
    // Register zero is constant and can never await a load.
    pend_d[0] = 1'b0;
  end

  // Pending-bit array with synchronous clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Operand hazard flags, cancelled by a writeback landing this very cycle.
  always_comb begin
    Pending1 = pend_q[ReadReg1] && !(RegWrite && (WriteReg == ReadReg1));
    Pending2 = pend_q[ReadReg2] && !(RegWrite && (WriteReg == ReadReg2));
  end

endmodule

// File: rtl/regfile_wb.sv
// Architectural register file terminating the writeback path. Owns the storage
// array, the write-to-read bypass for both decode operands and the raw debug
// port; the load-use scoreboard lives in reg_scoreboard.
module regfile_wb
  import mips_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  input  logic              KillValid,
  input  logic [ADDR_W-1:0] KillReg,
  output logic              Pending1,
  output logic              Pending2,
  output logic              Stall,
  input  logic [ADDR_W-1:0] DbgReg,
  output logic [DATA_W-1:0] DbgData
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              wr_en;

  // Writes to register zero are discarded so it always reads as zero.
  assign wr_en = RegWrite && (WriteReg != '0);

  // Storage next state: only the addressed register changes on a valid write.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WriteReg] = WriteData;
    end
    regs_d[0] = '0;
  end

  // Register array with synchronous clear; reset overrides a concurrent write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Operand read: zero register, else same-cycle writeback, else stored value.
  function automatic logic [DATA_W-1:0] read_port(
    input logic [ADDR_W-1:0] idx,
    input logic [DATA_W-1:0] stored
  );
    if (idx == '0) begin
      return '0;
    end else if (RegWrite && (WriteReg == idx)) begin
      return WriteData;
    end else begin
      return stored;
    end
  endfunction

  // Bypassed operand reads and the raw debug read.
  always_comb begin
    ReadData1 = read_port(ReadReg1, regs_q[ReadReg1]);
    ReadData2 = read_port(ReadReg2, regs_q[ReadReg2]);
    DbgData   = (DbgReg == '0) ? '0 : regs_q[DbgReg];
  end

  reg_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .KillValid  (KillValid),
    .KillReg    (KillReg),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .Pending1   (Pending1),
    .Pending2   (Pending2)
  );

  assign Stall = Pending1 | Pending2;

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: bypass, zero register, scoreboard priority and
// reset behaviour with hand-computed expectations.
module tb_regfile_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1, ReadReg2;
  logic [31:0] ReadData1, ReadData2;
  logic        IssueValid;
  logic [4:0]  IssueReg;
  logic        KillValid;
  logic [4:0]  KillReg;
  logic        Pending1, Pending2, Stall;
  logic [4:0]  DbgReg;
  logic [31:0] DbgData;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_wb dut (
    .clk        (clk),
    .reset      (reset),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .KillValid  (KillValid),
    .KillReg    (KillReg),
    .Pending1   (Pending1),
    .Pending2   (Pending2),
    .Stall      (Stall),
    .DbgReg     (DbgReg),
    .DbgData    (DbgData)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge and drop one-cycle strobes.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    RegWrite   = 1'b0;
    IssueValid = 1'b0;
    KillValid  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; RegWrite = 1'b0; WriteReg = '0; WriteData = '0;
    ReadReg1 = '0; ReadReg2 = '0; IssueValid = 1'b0; IssueReg = '0;
    KillValid = 1'b0; KillReg = '0; DbgReg = '0;
    next_cycle();
    next_cycle();
    reset = 1'b0;

    // Everything reads zero after reset.
    for (int i = 0; i < 32; i++) begin
      ReadReg1 = 5'(i); ReadReg2 = 5'(31 - i); DbgReg = 5'(i);
      #1;
      chk($sformatf("rst_rd1[%0d]", i), ReadData1, 32'h0);
      chk($sformatf("rst_rd2[%0d]", 31 - i), ReadData2, 32'h0);
      chk($sformatf("rst_dbg[%0d]", i), DbgData, 32'h0);
      chk($sformatf("rst_stall[%0d]", i), {31'b0, Stall}, 32'h0);
    end

    // Same-cycle bypass, then storage visible next cycle.
    RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hDEADBEEF;
    ReadReg1 = 5'd5; DbgReg = 5'd5;
    #1;
    chk("byp_rd1", ReadData1, 32'hDEADBEEF);
    chk("byp_dbg_not_yet", DbgData, 32'h0);
    next_cycle();
    chk("wr5_dbg", DbgData, 32'hDEADBEEF);
    chk("wr5_rd1", ReadData1, 32'hDEADBEEF);

    // Register zero ignores writes and is never bypassed.
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234; ReadReg2 = 5'd0; DbgReg = 5'd0;
    #1;
    chk("zero_rd2_same", ReadData2, 32'h0);
    next_cycle();
    chk("zero_rd2_after", ReadData2, 32'h0);
    chk("zero_dbg", DbgData, 32'h0);

    // Issue to zero is ignored.
    IssueValid = 1'b1; IssueReg = 5'd0; ReadReg1 = 5'd0;
    next_cycle();
    #1;
    chk("iss0_pend1", {31'b0, Pending1}, 32'h0);

    // Load-use: issue reg 8, pending next cycle, resolved by writeback.
    IssueValid = 1'b1; IssueReg = 5'd8; ReadReg1 = 5'd8; ReadReg2 = 5'd0;
    #1;
    chk("iss8_pend1_same", {31'b0, Pending1}, 32'h0);
    next_cycle();
    #1;
    chk("iss8_pend1", {31'b0, Pending1}, 32'h1);
    chk("iss8_stall", {31'b0, Stall}, 32'h1);
    next_cycle();
    #1;
    chk("iss8_pend1_hold", {31'b0, Pending1}, 32'h1);
    next_cycle();
    RegWrite = 1'b1; WriteReg = 5'd8; WriteData = 32'h55;
    #1;
    chk("wb8_pend1", {31'b0, Pending1}, 32'h0);
    chk("wb8_stall", {31'b0, Stall}, 32'h0);
    chk("wb8_rd1", ReadData1, 32'h55);
    next_cycle();
    #1;
    chk("wb8_pend1_after", {31'b0, Pending1}, 32'h0);
    chk("wb8_rd1_after", ReadData1, 32'h55);

    // Issue beats a simultaneous writeback; kill clears without touching storage.
    IssueValid = 1'b1; IssueReg = 5'd9;
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h99;
    ReadReg1 = 5'd0; ReadReg2 = 5'd9; DbgReg = 5'd9;
    #1;
    chk("iw9_rd2_byp", ReadData2, 32'h99);
    chk("iw9_pend2_same", {31'b0, Pending2}, 32'h0);
    next_cycle();
    #1;
    chk("iw9_pend2", {31'b0, Pending2}, 32'h1);
    chk("iw9_stall", {31'b0, Stall}, 32'h1);
    chk("iw9_dbg", DbgData, 32'h99);
    KillValid = 1'b1; KillReg = 5'd9;
    #1;
    chk("kill9_pend2_same", {31'b0, Pending2}, 32'h1);
    next_cycle();
    #1;
    chk("kill9_pend2", {31'b0, Pending2}, 32'h0);
    chk("kill9_dbg", DbgData, 32'h99);
    chk("kill9_rd2", ReadData2, 32'h99);

    // Reset clears storage and scoreboard and beats a concurrent write/issue.
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hA5A5A5A5;
    next_cycle();
    IssueValid = 1'b1; IssueReg = 5'd3; ReadReg1 = 5'd3;
    next_cycle();
    #1;
    chk("r3_pend1", {31'b0, Pending1}, 32'h1);
    chk("r3_rd1", ReadData1, 32'hA5A5A5A5);
    reset = 1'b1;
    RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h77;
    IssueValid = 1'b1; IssueReg = 5'd4;
    next_cycle();
    reset = 1'b0;
    ReadReg2 = 5'd4; DbgReg = 5'd4;
    #1;
    chk("rst_r3_rd1", ReadData1, 32'h0);
    chk("rst_r3_pend1", {31'b0, Pending1}, 32'h0);
    chk("rst_r4_dbg", DbgData, 32'h0);
    chk("rst_r4_pend2", {31'b0, Pending2}, 32'h0);
    chk("rst_stall", {31'b0, Stall}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
